// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NREQ writeback sources.
// After reset it sweeps zeros into R1..R(max) before accepting any requester.
module rf_write_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic                     init_done,
    output logic [7:0]               drop_cnt
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [ADDR_W-1:0] LAST_REG = '1;
    // Pointer value whose successor is NREQ-1, so the first grant after reset goes to the top requester.
    localparam logic [PTR_W-1:0]  RR_RESET = PTR_W'(NREQ - 2);

    typedef enum logic {INIT, RUN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   init_ptr;
    logic [PTR_W-1:0]    rr_ptr;

    logic                gnt_found;
    logic [PTR_W-1:0]    gnt_idx;
    logic [ADDR_W-1:0]   gnt_addr;
    logic [DATA_W-1:0]   gnt_data;

    // Search from rr_ptr+1 upward with wrap; gnt_found stops later candidates from overriding.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        req_ready = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_addr  = '0;
        gnt_data  = '0;
        if (state == RUN) begin
            for (int k = 1; k <= NREQ; k++) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!gnt_found && req_valid[i] && ((int'(rr_ptr) + k) % NREQ) == i) begin
                        gnt_found    = 1'b1;
                        req_ready[i] = 1'b1;
                        gnt_idx      = PTR_W'(i);
                        gnt_addr     = req_addr[i*ADDR_W +: ADDR_W];
                        gnt_data     = req_data[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT;
            init_ptr  <= ADDR_W'(1);
            rr_ptr    <= RR_RESET;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            init_done <= 1'b0;
            drop_cnt  <= '0;
        end else if (state == INIT) begin
            rf_we    <= 1'b1;
            rf_waddr <= init_ptr;
            rf_wdata <= '0;
            init_ptr <= init_ptr + 1'b1;
            if (init_ptr == LAST_REG) begin
                state     <= RUN;
                init_done <= 1'b1;
            end
        end else begin
            rf_we <= 1'b0;
            if (gnt_found) begin
                rr_ptr   <= gnt_idx;
                rf_waddr <= gnt_addr;
                rf_wdata <= gnt_data;
                // Writes to R0 are accepted but never reach the RF; they are only counted.
                if (gnt_addr != '0)
                    rf_we <= 1'b1;
                else if (drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: each driven cycle pushes the expected registered
// write-port state, which is popped and compared one edge later.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        init_done;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    rf_write_arbiter #(.NREQ(2), .ADDR_W(5), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .init_done (init_done),
        .drop_cnt  (drop_cnt)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        done;
        logic [7:0]  drop;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          init_left;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [7:0]  m_drop;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        init_left = 31;
        m_addr    = '0;
        m_data    = '0;
        m_drop    = '0;
    endtask

    // One clock cycle: drive requests, check the grant, push the expected write, then
    // compare the registered outputs after the edge against the scoreboard head.
    task automatic cycle(input logic [1:0] v, input logic [1:0] exp_rdy);
        exp_t e, got;
        logic [4:0] ga;
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
        #1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        e.we = 1'b0;
        if (init_left > 0) begin
            m_addr = 5'(32 - init_left);
            m_data = '0;
            e.we   = 1'b1;
            init_left--;
        end else if (exp_rdy != 2'b00) begin
            ga     = exp_rdy[1] ? a1 : a0;
            m_addr = ga;
            m_data = exp_rdy[1] ? d1 : d0;
            e.we   = (ga != 5'd0);
            if (ga == 5'd0 && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        end
        e.addr = m_addr;
        e.data = m_data;
        e.done = (init_left == 0);
        e.drop = m_drop;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = {rf_we, rf_waddr, rf_wdata, init_done, drop_cnt};
        if (sb.size() == 0) begin
            check("sb_underflow", 64'(1), 64'(0));
        end else begin
            e = sb.pop_front();
            check("rf_port", 64'(got), 64'(e));
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_we"},    64'(rf_we),     64'(0));
        check({tag, "_waddr"}, 64'(rf_waddr),  64'(0));
        check({tag, "_wdata"}, 64'(rf_wdata),  64'(0));
        check({tag, "_done"},  64'(init_done), 64'(0));
        check({tag, "_drop"},  64'(drop_cnt),  64'(0));
        check({tag, "_ready"}, 64'(req_ready), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        a0 = 5'd1; d0 = 32'd4;
        a1 = 5'd2; d1 = 32'h22;
        model_reset();

        // Reset state, with requests already pending.
        repeat (2) @(posedge clk);
        #1;
        req_valid = 2'b11;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
        #1;
        check_reset_state("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Init sweep R1..R31 with zero data; pending requests see no grant.
        repeat (31) cycle(2'b11, 2'b00);
        // First RUN cycle grants the top requester.
        cycle(2'b11, 2'b10);
        // Single requester: R1 <= 4 one edge after acceptance.
        cycle(2'b01, 2'b01);
        cycle(2'b00, 2'b00);

        // Both held valid: strict alternation, one write per cycle.
        a0 = 5'd1; d0 = 32'hA0;
        a1 = 5'd2; d1 = 32'hB1;
        for (int i = 0; i < 6; i++) cycle(2'b11, (i % 2 == 0) ? 2'b10 : 2'b01);
        cycle(2'b00, 2'b00);

        // Same register from both: grant order is RF write order.
        a0 = 5'd7; d0 = 32'd70;
        a1 = 5'd7; d1 = 32'd71;
        cycle(2'b11, 2'b10);
        cycle(2'b01, 2'b01);

        // Write to R0 is accepted but dropped and counted.
        a0 = 5'd0; d0 = 32'hDEAD;
        cycle(2'b01, 2'b01);
        cycle(2'b00, 2'b00);

        // Drop counter saturates at 255.
        repeat (256) cycle(2'b01, 2'b01);

        // Reset mid-stream: in-flight write cancelled immediately, sweep restarts.
        a0 = 5'd3; d0 = 32'd33;
        a1 = 5'd4; d1 = 32'd44;
        cycle(2'b11, 2'b10);
        #2;
        rst = 1'b0;
        #1;
        check_reset_state("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (31) cycle(2'b11, 2'b00);
        cycle(2'b11, 2'b10);
        cycle(2'b01, 2'b01);
        cycle(2'b00, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
